rec_net_feeder: RTL and testbench

REC_NET_FEEDER -- requirements
Module: rec_net_feeder

---
 rtl/rec_net_pkg.sv | 30 +++
 rtl/rec_net_beat_packer.sv | 55 +++++
 rtl/rec_net_feeder.sv | 130 +++++++++++++
 tb/tb_rec_net_feeder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rec_net_pkg.sv
// Shared FSM encoding and fill-length helpers for the rec_net feeder.
package rec_net_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL_STAT,
    FILL_OP,
    ISSUE_STAT,
    ISSUE_OP
  } state_e;

  // Beats needed to assemble one stationary vector.
  function automatic int unsigned stat_beats(input int unsigned num_mult,
                                             input int unsigned in_words);
    return num_mult / in_words;
  endfunction

  // Beats needed to assemble one operand vector (all cores).
  function automatic int unsigned op_beats(input int unsigned num_cores,
                                           input int unsigned num_mult,
                                           input int unsigned in_words);
    return (num_cores * num_mult) / in_words;
  endfunction

  // Counter width for n beats, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rec_net_beat_packer.sv
// Beat counter plus assembly buffer; each accepted beat lands in the slot
// selected by the counter. buf_next exposes the buffer including this
// cycle's write so the top can capture a finished vector on the final beat.
module rec_net_beat_packer #(
  parameter int unsigned NUM_BEATS = 8,
  parameter int unsigned BEAT_W    = 16,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic                        last,
  input  logic                        clr,
  input  logic [BEAT_W-1:0]           beat,
  output logic [CNT_W-1:0]            cnt,
  output logic [NUM_BEATS*BEAT_W-1:0] buf_next
);

  logic [NUM_BEATS-1:0][BEAT_W-1:0] buf_q, buf_d;
  logic [NUM_BEATS-1:0]             slot_we;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  for (genvar k = 0; k < NUM_BEATS; k++) begin : g_slot
    assign slot_we[k] = wr_en && (cnt_q == CNT_W'(k));
  end

  // Counter: advance per accepted beat, wrap after the last, clear on discard.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)        cnt_d = '0;
    else if (wr_en) cnt_d = last ? '0 : cnt_q + CNT_W'(1);
  end

  // Buffer: write the beat into the slot picked by the counter.
  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < NUM_BEATS; k++)
      if (slot_we[k]) buf_d[k] = beat;
  end

  // Counter and buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  assign cnt      = cnt_q;
  assign buf_next = buf_d;

endmodule

// File: rtl/rec_net_feeder.sv
// Assembles input beats into stationary/operand vectors and presents them
// to the cores. Output registers are loaded on the edge that accepts a
// fill's final beat, so the new vector is on input_vec during the one-cycle
// ISSUE state together with its stat_bit / op_issue pulse.
module rec_net_feeder
  import rec_net_pkg::*;
#(
  parameter int unsigned NUM_MULT  = 256,
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned IN_WORDS  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IN_WORDS*WORD_SIZE-1:0]       in_data,
  input  logic                                in_is_stat,
  input  logic                                flush,
  output logic                                stat_bit,
  output logic [NUM_CORES*NUM_MULT*WORD_SIZE-1:0] input_vec,
  output logic                                op_issue,
  output logic [15:0]                         issue_cnt
);

  localparam int unsigned STAT_BEATS = stat_beats(NUM_MULT, IN_WORDS);
  localparam int unsigned OP_BEATS   = op_beats(NUM_CORES, NUM_MULT, IN_WORDS);
  localparam int unsigned CNT_W      = cnt_width(OP_BEATS);
  localparam int unsigned BEAT_W     = IN_WORDS * WORD_SIZE;
  localparam int unsigned STAT_W     = NUM_MULT * WORD_SIZE;
  localparam int unsigned VEC_W      = NUM_CORES * STAT_W;

  state_e             state_q, state_d;
  logic [STAT_W-1:0]  stat_q, stat_d;
  logic [VEC_W-1:0]   op_q, op_d;
  logic [15:0]        issue_cnt_q, issue_cnt_d;

  logic               in_fill, drop, accept, is_stat_fill, last;
  logic [CNT_W-1:0]   cnt;
  logic [VEC_W-1:0]   buf_next;

  // Handshake and fill bookkeeping; a flushed fill ignores that cycle's beat.
  always_comb begin
    in_ready     = (state_q == IDLE) || (state_q == FILL_STAT) || (state_q == FILL_OP);
    in_fill      = (state_q == FILL_STAT) || (state_q == FILL_OP);
    drop         = flush && in_fill;
    accept       = in_valid && in_ready && !drop;
    is_stat_fill = (state_q == IDLE) ? in_is_stat : (state_q == FILL_STAT);
    last         = is_stat_fill ? (cnt == CNT_W'(STAT_BEATS - 1))
                                : (cnt == CNT_W'(OP_BEATS - 1));
  end

  rec_net_beat_packer #(
    .NUM_BEATS (OP_BEATS),
    .BEAT_W    (BEAT_W),
    .CNT_W     (CNT_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .last     (last),
    .clr      (drop),
    .beat     (in_data),
    .cnt      (cnt),
    .buf_next (buf_next)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (accept) begin
          if (last) state_d = is_stat_fill ? ISSUE_STAT : ISSUE_OP;
          else      state_d = is_stat_fill ? FILL_STAT  : FILL_OP;
        end
      FILL_STAT:
        if (drop)                 state_d = IDLE;
        else if (accept && last)  state_d = ISSUE_STAT;
      FILL_OP:
        if (drop)                 state_d = IDLE;
        else if (accept && last)  state_d = ISSUE_OP;
      ISSUE_STAT, ISSUE_OP:       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Capture completed vectors and bump the issue count on the final beat.
  always_comb begin
    stat_d      = stat_q;
    op_d        = op_q;
    issue_cnt_d = issue_cnt_q;
    if (accept && last) begin
      if (is_stat_fill) begin
        stat_d = buf_next[STAT_W-1:0];
      end else begin
        op_d        = buf_next;
        issue_cnt_d = issue_cnt_q + 16'd1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stat_q      <= '0;
      op_q        <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stat_q      <= stat_d;
      op_q        <= op_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign stat_bit  = (state_q == ISSUE_STAT);
  assign op_issue  = (state_q == ISSUE_OP);
  assign issue_cnt = issue_cnt_q;

  // Stationary data only ever replaces the low core slot, and only while
  // stat_bit is high, so the core's operand latch never sees it.
  if (NUM_CORES > 1) begin : g_mux
    assign input_vec = stat_bit ? {op_q[VEC_W-1:STAT_W], stat_q} : op_q;
  end else begin : g_mux1
    assign input_vec = stat_bit ? stat_q : op_q;
  end

endmodule

// File: tb/tb_rec_net_feeder.sv
// Directed bench for rec_net_feeder at NUM_MULT=4, NUM_CORES=2, WORD_SIZE=8,
// IN_WORDS=2 (2-beat stationary fill, 4-beat operand fill).
module tb_rec_net_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_is_stat = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, stat_bit, op_issue;
  logic [63:0] input_vec;
  logic [15:0] issue_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rec_net_feeder #(
    .NUM_MULT  (4),
    .NUM_CORES (2),
    .WORD_SIZE (8),
    .IN_WORDS  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_is_stat (in_is_stat),
    .flush      (flush),
    .stat_bit   (stat_bit),
    .input_vec  (input_vec),
    .op_issue   (op_issue),
    .issue_cnt  (issue_cnt)
  );

  // Offer one beat at a negedge; returns at the next negedge.
  task automatic beat(input logic [15:0] d, input logic s);
    in_valid   = 1'b1;
    in_data    = d;
    in_is_stat = s;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (stat_bit !== 1'b0) begin errors++; $display("FAIL reset_stat_bit: got %b want 0", stat_bit); end
    checks++; if (op_issue !== 1'b0) begin errors++; $display("FAIL reset_op_issue: got %b want 0", op_issue); end
    checks++; if (input_vec !== 64'h0) begin errors++; $display("FAIL reset_input_vec: got %h want 0", input_vec); end
    checks++; if (issue_cnt !== 16'h0) begin errors++; $display("FAIL reset_issue_cnt: got %h want 0", issue_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_operand();
    beat(16'h1211, 1'b0);
    beat(16'h1413, 1'b0);
    checks++; if (input_vec !== 64'h0) begin errors++; $display("FAIL op_partial_hidden: got %h want 0", input_vec); end
    checks++; if (op_issue !== 1'b0) begin errors++; $display("FAIL op_early_issue: got %b want 0", op_issue); end
    beat(16'h1615, 1'b0);
    beat(16'h1817, 1'b0);
    checks++; if (op_issue !== 1'b1) begin errors++; $display("FAIL op_issue_pulse: got %b want 1", op_issue); end
    checks++; if (input_vec !== 64'h1817161514131211) begin errors++; $display("FAIL op_vec: got %h want 1817161514131211", input_vec); end
    checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL op_issue_cnt: got %h want 0001", issue_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL op_stall: got %b want 0", in_ready); end
    @(negedge clk);
    checks++; if (op_issue !== 1'b0) begin errors++; $display("FAIL op_pulse_end: got %b want 0", op_issue); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL op_ready_back: got %b want 1", in_ready); end
    checks++; if (input_vec !== 64'h1817161514131211) begin errors++; $display("FAIL op_vec_hold: got %h want 1817161514131211", input_vec); end
  endtask

  // Flush is held on the first beat (IDLE: no effect); in_is_stat=0 on the
  // second beat must be ignored.
  task automatic test_stationary();
    flush = 1'b1;
    beat(16'h0201, 1'b1);
    flush = 1'b0;
    checks++; if (stat_bit !== 1'b0) begin errors++; $display("FAIL stat_early: got %b want 0", stat_bit); end
    beat(16'h0403, 1'b0);
    checks++; if (stat_bit !== 1'b1) begin errors++; $display("FAIL stat_bit_pulse: got %b want 1", stat_bit); end
    checks++; if (input_vec !== 64'h1817161504030201) begin errors++; $display("FAIL stat_vec: got %h want 1817161504030201", input_vec); end
    checks++; if (op_issue !== 1'b0) begin errors++; $display("FAIL stat_no_op_issue: got %b want 0", op_issue); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stat_stall: got %b want 0", in_ready); end
    @(negedge clk);
    checks++; if (stat_bit !== 1'b0) begin errors++; $display("FAIL stat_pulse_end: got %b want 0", stat_bit); end
    checks++; if (input_vec !== 64'h1817161514131211) begin errors++; $display("FAIL stat_vec_restore: got %h want 1817161514131211", input_vec); end
    checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL stat_cnt_same: got %h want 0001", issue_cnt); end
  endtask

  task automatic test_flush();
    beat(16'hE2E1, 1'b0);
    beat(16'hE4E3, 1'b0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || op_issue !== 1'b0) begin errors++; $display("FAIL flush_idle: got rdy=%b iss=%b want rdy=1 iss=0", in_ready, op_issue); end
    beat(16'hA2A1, 1'b0);
    beat(16'hA4A3, 1'b0);
    beat(16'hA6A5, 1'b0);
    checks++; if (op_issue !== 1'b0) begin errors++; $display("FAIL flush_early_issue: got %b want 0", op_issue); end
    beat(16'hA8A7, 1'b0);
    checks++; if (op_issue !== 1'b1) begin errors++; $display("FAIL flush_issue: got %b want 1", op_issue); end
    checks++; if (input_vec !== 64'hA8A7A6A5A4A3A2A1) begin errors++; $display("FAIL flush_vec: got %h want A8A7A6A5A4A3A2A1", input_vec); end
    checks++; if (issue_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnt: got %h want 0002", issue_cnt); end
    @(negedge clk);
  endtask

  // Two operand fills with in_valid held high; in_is_stat=1 on non-first
  // beats must be ignored.
  task automatic test_back_to_back();
    logic [15:0] bb [8];
    int idx, stalls, pulses, guard;
    logic acc;
    bb = '{16'h4241, 16'h4443, 16'h4645, 16'h4847,
           16'h5251, 16'h5453, 16'h5655, 16'h5857};
    idx = 0; stalls = 0; pulses = 0; guard = 0;
    in_valid = 1'b1;
    while (idx < 8 && guard < 20) begin
      in_data    = bb[idx];
      in_is_stat = (idx % 4 != 0);
      acc = in_ready;
      if (!acc) stalls++;
      if (op_issue) pulses++;
      @(negedge clk);
      guard++;
      if (acc) idx++;
    end
    in_valid   = 1'b0;
    in_is_stat = 1'b0;
    if (op_issue) pulses++;
    checks++; if (guard >= 20) begin errors++; $display("FAIL b2b_timeout: got %0d beats want 8", idx); end
    checks++; if (stalls !== 1) begin errors++; $display("FAIL b2b_stalls: got %0d want 1", stalls); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    checks++; if (input_vec !== 64'h5857565554535251) begin errors++; $display("FAIL b2b_vec: got %h want 5857565554535251", input_vec); end
    checks++; if (issue_cnt !== 16'd4) begin errors++; $display("FAIL b2b_cnt: got %h want 0004", issue_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    beat(16'h6261, 1'b0);
    beat(16'h6463, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h6665;
    #2 rst = 1'b1;
    #1;
    checks++; if (input_vec !== 64'h0 || issue_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_clear: got vec=%h cnt=%h want 0", input_vec, issue_cnt); end
    checks++; if (op_issue !== 1'b0 || stat_bit !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ctrl: got iss=%b st=%b rdy=%b want 0 0 1", op_issue, stat_bit, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    checks++; if (op_issue !== 1'b0) begin errors++; $display("FAIL rstmid_no_issue: got %b want 0", op_issue); end
    beat(16'h3231, 1'b0);
    beat(16'h3433, 1'b0);
    beat(16'h3635, 1'b0);
    checks++; if (op_issue !== 1'b0) begin errors++; $display("FAIL rstmid_early: got %b want 0", op_issue); end
    beat(16'h3837, 1'b0);
    checks++; if (op_issue !== 1'b1) begin errors++; $display("FAIL rstmid_issue: got %b want 1", op_issue); end
    checks++; if (input_vec !== 64'h3837363534333231) begin errors++; $display("FAIL rstmid_vec: got %h want 3837363534333231", input_vec); end
    checks++; if (issue_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_cnt: got %h want 0001", issue_cnt); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    force dut.issue_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.issue_cnt_q;
    @(negedge clk);
    checks++; if (issue_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want FFFF", issue_cnt); end
    beat(16'h7271, 1'b0);
    beat(16'h7473, 1'b0);
    beat(16'h7675, 1'b0);
    beat(16'h7877, 1'b0);
    checks++; if (op_issue !== 1'b1) begin errors++; $display("FAIL wrap_issue: got %b want 1", op_issue); end
    checks++; if (issue_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h want 0000", issue_cnt); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_operand();
    test_stationary();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
